// File: rtl/grid_diff_scanner_if.sv
// Update-record channel from grid_diff_scanner to the downstream tile drawer.
// The master drives a {x,y,code} record with out_valid; the slave accepts it with out_ready.
interface grid_diff_scanner_if #(
    parameter int XW     = 4,
    parameter int YW     = 4,
    parameter int CODE_W = 3
);
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] obj_code;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;

    modport master (output out_valid, output obj_code, output x, output y, input out_ready);
    modport slave  (input out_valid, input obj_code, input x, input y, output out_ready);
endinterface

// File: rtl/grid_diff_scanner.sv
// grid_diff_scanner: raster-scans a GRID_W x GRID_H tile grid, priority-encodes the
// object-hit flags of each sampled cell into a tile code, keeps one stored code per cell
// and emits a {x,y,code} record only when a cell's code changes.
// Optional feature macro: GRID_DIFF_REDRAW_EN adds i_redraw, which (when high on the
// sample of cell (0,0)) forces a record for every cell of that frame.
module grid_diff_scanner #(
    parameter  int GRID_W  = 16,
    parameter  int GRID_H  = 12,
    parameter  int NUM_OBJ = 4,
    parameter  int CODE_W  = 3,
    localparam int XW      = $clog2(GRID_W),
    localparam int YW      = $clog2(GRID_H)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               i_enable,
    input  logic [NUM_OBJ-1:0] i_obj_hit,
`ifdef GRID_DIFF_REDRAW_EN
    input  logic               i_redraw,
`endif
    output logic [XW-1:0]      o_cur_x,
    output logic [YW-1:0]      o_cur_y,
    output logic               o_frame_done,
    grid_diff_scanner_if.master bus
);

    localparam int NCELL = GRID_W * GRID_H;
    localparam int IDXW  = $clog2(NCELL);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_STALL} state_t;

    state_t            r_state;
    logic [XW-1:0]     r_cur_x;
    logic [YW-1:0]     r_cur_y;
    logic              r_out_valid;
    logic [CODE_W-1:0] r_code;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic              r_frame_done;
    logic [CODE_W-1:0] r_cell [NCELL];

    logic [CODE_W-1:0] w_new_code;
    logic [CODE_W-1:0] w_stored;
    logic [IDXW-1:0]   w_idx;
    logic [NCELL-1:0]  w_cell_we;
    logic              w_stall;
    logic              w_sample;
    logic              w_accept;
    logic              w_last_x;
    logic              w_last_y;
    logic              w_force;
    logic              w_emit;

    // Priority encoder: later (higher) indices overwrite earlier ones, so the highest hit wins
    always_comb begin
        w_new_code = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (i_obj_hit[i]) begin
                w_new_code = CODE_W'(i + 1);
            end
        end
    end

    assign w_idx    = IDXW'(r_cur_y) * IDXW'(GRID_W) + IDXW'(r_cur_x);
    assign w_stored = r_cell[w_idx];
    assign w_stall  = r_out_valid & ~bus.out_ready;
    assign w_sample = i_enable & ~w_stall;
    assign w_accept = r_out_valid & bus.out_ready;
    assign w_last_x = (r_cur_x == XW'(GRID_W - 1));
    assign w_last_y = (r_cur_y == YW'(GRID_H - 1));
    assign w_emit   = (w_new_code != w_stored) | w_force;

`ifdef GRID_DIFF_REDRAW_EN
    logic r_redraw_arm;
    logic w_at_origin;

    assign w_at_origin = (r_cur_x == '0) && (r_cur_y == '0);
    // The origin sample decides the arm directly so cell (0,0) itself is redrawn too
    assign w_force     = w_at_origin ? i_redraw : r_redraw_arm;

    // Redraw arm: latched on the origin sample, dropped after the last cell of the frame
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_redraw_arm <= 1'b0;
        end else if (w_sample) begin
            if (w_at_origin) begin
                r_redraw_arm <= i_redraw;
            end else if (w_last_x && w_last_y) begin
                r_redraw_arm <= 1'b0;
            end
        end
    end
`else
    assign w_force = 1'b0;
`endif

    // Per-cell write strobes: only the cell under the cursor is written on a sample
    generate
        for (genvar gi = 0; gi < NCELL; gi++) begin : g_cell_we
            assign w_cell_we[gi] = w_sample && (w_idx == IDXW'(gi));
        end
    endgenerate

    // Stored tile codes: flip-flops so a single reset edge can blank the whole grid
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCELL; i++) begin
            if (!nrst) begin
                r_cell[i] <= '0;
            end else if (w_cell_we[i]) begin
                r_cell[i] <= w_new_code;
            end
        end
    end

    // Cursor, update record, frame pulse and scan state
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_out_valid  <= 1'b0;
            r_code       <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_sample && w_last_x && w_last_y;

            if (w_sample) begin
                if (w_last_x) begin
                    r_cur_x <= '0;
                    r_cur_y <= w_last_y ? '0 : r_cur_y + YW'(1);
                end else begin
                    r_cur_x <= r_cur_x + XW'(1);
                end

                // A sample only happens when any previous record is gone or being accepted,
                // so loading a new record here never overwrites a pending one
                if (w_emit) begin
                    r_out_valid <= 1'b1;
                    r_code      <= w_new_code;
                    r_x         <= r_cur_x;
                    r_y         <= r_cur_y;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_sample && w_emit && !bus.out_ready) begin
                        r_state <= S_STALL;
                    end else if (!i_enable && !w_stall) begin
                        r_state <= S_IDLE;
                    end
                end
                S_STALL: begin
                    if (bus.out_ready) begin
                        r_state <= i_enable ? S_SCAN : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cur_x      = r_cur_x;
    assign o_cur_y      = r_cur_y;
    assign o_frame_done = r_frame_done;
    assign bus.out_valid = r_out_valid;
    assign bus.obj_code  = r_code;
    assign bus.x         = r_x;
    assign bus.y         = r_y;

endmodule

// File: tb/tb_grid_diff_scanner.sv
// Testbench for grid_diff_scanner: directed scenes plus randomized scenes, enable and
// ready patterns, checked cycle by cycle against a cell-array reference model.
module tb_grid_diff_scanner;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int N  = 4;
    localparam int CW = 3;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int NC = W * H;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          enable = 1'b0;
    logic [N-1:0]  obj_hit = '0;
    logic          redraw = 1'b0;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          frame_done;

    grid_diff_scanner_if #(.XW(XW), .YW(YW), .CODE_W(CW)) bus ();

    grid_diff_scanner #(.GRID_W(W), .GRID_H(H), .NUM_OBJ(N), .CODE_W(CW)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_enable     (enable),
        .i_obj_hit    (obj_hit),
`ifdef GRID_DIFF_REDRAW_EN
        .i_redraw     (redraw),
`endif
        .o_cur_x      (cur_x),
        .o_cur_y      (cur_y),
        .o_frame_done (frame_done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int           m_mem [NC];
    logic [N-1:0] scene [NC];
    int           m_idx;
    bit           m_valid;
    int           m_code, m_x, m_y;
    bit           m_fd;
    bit           m_arm;
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_fail   = 0;
    int           n_acc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int enc(input logic [N-1:0] h);
        for (int i = N - 1; i >= 0; i--) begin
            if (h[i]) return i + 1;
        end
        return 0;
    endfunction

    // One clock cycle: check outputs, drive inputs, advance the model, wait to next negedge
    task automatic step(input bit en, input bit rdy, input bit rd);
        bit stall, samp, emit, frc;
        int c;
        check("cur_x", cur_x, m_idx % W);
        check("cur_y", cur_y, m_idx / W);
        check("out_valid", bus.out_valid, m_valid);
        if (m_valid) begin
            check("obj_code", bus.obj_code, m_code);
            check("rec_x", bus.x, m_x);
            check("rec_y", bus.y, m_y);
        end
        check("frame_done", frame_done, m_fd);
        if (bus.out_valid === 1'b1 && rdy) n_acc++;

        enable        = en;
        bus.out_ready = rdy;
        redraw        = rd;
        obj_hit       = scene[m_idx];

        stall = m_valid && !rdy;
        samp  = en && !stall;
        m_fd  = 1'b0;
        if (samp) begin
            c   = enc(obj_hit);
            frc = 1'b0;
`ifdef GRID_DIFF_REDRAW_EN
            if (m_idx == 0) m_arm = rd;
            frc = m_arm;
            if (m_idx == NC - 1) m_arm = 1'b0;
`endif
            emit = (c != m_mem[m_idx]) || frc;
            m_mem[m_idx] = c;
            if (emit) begin
                m_valid = 1'b1;
                m_code  = c;
                m_x     = m_idx % W;
                m_y     = m_idx / W;
            end else begin
                m_valid = 1'b0;
            end
            if (m_idx == NC - 1) m_fd = 1'b1;
            m_idx = (m_idx + 1) % NC;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    // One reset edge, then the full reset state is checked
    task automatic do_reset(input bit rdy);
        nrst          = 1'b0;
        enable        = 1'b1;
        bus.out_ready = rdy;
        obj_hit       = scene[m_idx];
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < NC; i++) m_mem[i] = 0;
        m_idx = 0; m_valid = 1'b0; m_code = 0; m_x = 0; m_y = 0; m_fd = 1'b0; m_arm = 1'b0;
        check("rst_cur_x", cur_x, 0);
        check("rst_cur_y", cur_y, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_code", bus.obj_code, 0);
        check("rst_x", bus.x, 0);
        check("rst_y", bus.y, 0);
        check("rst_frame_done", frame_done, 0);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            scene[i] = '0;
            m_mem[i] = 0;
        end
        m_idx = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset, then a blank frame: no records, frame_done after the last cell
        do_reset(1'b1);
        repeat (NC + 1) step(1'b1, 1'b1, 1'b0);

        // Head at (3,2): one record, then nothing on the following frame
        scene[2 * W + 3] = 4'b0001;
        n_acc = 0;
        repeat (NC) step(1'b1, 1'b1, 1'b0);
        check("head_records", n_acc, 1);
        n_acc = 0;
        repeat (NC) step(1'b1, 1'b1, 1'b0);
        check("static_records", n_acc, 0);

        // Border beats body at (0,0), then clearing it emits code 0
        scene[0] = 4'b1010;
        repeat (NC) step(1'b1, 1'b1, 1'b0);
        scene[0] = 4'b0000;
        repeat (NC) step(1'b1, 1'b1, 1'b0);

        // Downstream not ready: cursor freezes on a pending record, then resumes
        scene[5] = 4'b0100;
        repeat (13) step(1'b1, 1'b0, 1'b0);
        check("stall_held", bus.out_valid, 1);
        repeat (NC) step(1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);

        // Reset while stalled: record dropped, grid blanked, nonblank cells re-emitted
        scene[20] = 4'b1000;
        for (int k = 0; k < 2 * NC && !m_valid; k++) step(1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        check("pre_reset_valid", bus.out_valid, 1);
        do_reset(1'b0);
        n_acc = 0;
        repeat (NC + 1) step(1'b1, 1'b1, 1'b0);
        check("reemit_records", n_acc, 3);

        // Randomized scenes, enable and ready
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NC; i++) begin
                if ($urandom_range(0, 9) < 3) scene[i] = N'($urandom_range(0, 15));
            end
            repeat (NC + 40) step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0), 1'b0);
        end

`ifdef GRID_DIFF_REDRAW_EN
        // Full redraw of a static scene, then nothing on the following frame
        for (int k = 0; k < 2 * NC && (m_idx != 0 || m_valid); k++) step(1'b1, 1'b1, 1'b0);
        repeat (NC) step(1'b1, 1'b1, 1'b0);
        n_acc = 0;
        step(1'b1, 1'b1, 1'b1);
        repeat (NC) step(1'b1, 1'b1, 1'b0);
        check("redraw_records", n_acc, NC);
        n_acc = 0;
        repeat (NC) step(1'b1, 1'b1, 1'b0);
        check("post_redraw_records", n_acc, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
